// File: rtl/sram_arbiter_pkg.sv
// rtl/sram_arbiter_pkg.sv - memory op codes shared by the SRAM arbiter and its helpers
package sram_arbiter_pkg;

    typedef logic [3:0] mem_op_t;

    localparam mem_op_t RAM_NOP = 4'b0000;
    localparam mem_op_t MEM_LB  = 4'd1;
    localparam mem_op_t MEM_LH  = 4'd2;
    localparam mem_op_t MEM_LW  = 4'd3;
    localparam mem_op_t MEM_LBU = 4'd4;
    localparam mem_op_t MEM_LHU = 4'd5;
    localparam mem_op_t MEM_SB  = 4'd6;
    localparam mem_op_t MEM_SH  = 4'd7;
    localparam mem_op_t MEM_SW  = 4'd8;

endpackage

// File: rtl/sram_arbiter_if.sv
// rtl/sram_arbiter_if.sv - pipeline request ports and SRAM controller bus of the arbiter
interface sram_arbiter_if;
    import sram_arbiter_pkg::*;

    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_data_o;
    logic        if_ready_o;
    mem_op_t     mem_op_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic [31:0] mem_rdata_o;
    logic        mem_ready_o;
    logic        addr_err_o;
    logic        stall_o;
    logic [19:0] ramAddr_o;
    logic [31:0] storeData_o;
    mem_op_t     ramOp_o;
    logic [31:0] loadData_i;
    logic        success_i;

    modport slave (
        input  if_req_i, if_addr_i, mem_op_i, mem_addr_i, mem_wdata_i, loadData_i, success_i,
        output if_data_o, if_ready_o, mem_rdata_o, mem_ready_o, addr_err_o, stall_o,
               ramAddr_o, storeData_o, ramOp_o
    );

    modport master (
        output if_req_i, if_addr_i, mem_op_i, mem_addr_i, mem_wdata_i, loadData_i, success_i,
        input  if_data_o, if_ready_o, mem_rdata_o, mem_ready_o, addr_err_o, stall_o,
               ramAddr_o, storeData_o, ramOp_o
    );

endinterface

// File: rtl/sram_store_align.sv
// rtl/sram_store_align.sv - moves store data to its top lanes and flags misaligned data accesses
module sram_store_align
    import sram_arbiter_pkg::*;
(
    input  mem_op_t     op_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] data_o,
    output logic        misaligned_o
);

    // The controller steers bytes/halfwords from the top lanes, so narrow stores are left-justified.
    always_comb begin
        data_o       = 32'h0;
        misaligned_o = 1'b0;
        case (op_i)
            MEM_SW: begin
                data_o       = wdata_i;
                misaligned_o = (addr_lo_i != 2'b00);
            end
            MEM_SH: begin
                data_o       = {wdata_i[15:0], 16'h0};
                misaligned_o = addr_lo_i[0];
            end
            MEM_SB:          data_o       = {wdata_i[7:0], 24'h0};
            MEM_LW:          misaligned_o = (addr_lo_i != 2'b00);
            MEM_LH, MEM_LHU: misaligned_o = addr_lo_i[0];
            default: ;
        endcase
    end

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - data-priority arbiter between fetch and data ports in front of the SRAM controller
module sram_arbiter
    import sram_arbiter_pkg::*;
(
    input  logic          clk50,
    input  logic          rst,
    sram_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, DATA, INST, GAP} state_e;

    state_e      state_q, state_d;
    mem_op_t     ram_op_q, ram_op_d;
    logic [19:0] ram_addr_q, ram_addr_d;
    logic [31:0] store_data_q, store_data_d;
    logic [31:0] if_data_q, if_data_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic        if_ready_q, if_ready_d;
    logic        mem_ready_q, mem_ready_d;
    logic        addr_err_q, addr_err_d;
    logic        err_mem_q, err_mem_d;
    logic [31:0] aligned_wdata;
    logic        mem_misaligned;
    logic        mem_req;
    logic        if_done, mem_done;
    logic        unused_addr_bits;

    sram_store_align u_store_align (
        .op_i         (bus.mem_op_i),
        .addr_lo_i    (bus.mem_addr_i[1:0]),
        .wdata_i      (bus.mem_wdata_i),
        .data_o       (aligned_wdata),
        .misaligned_o (mem_misaligned)
    );

    assign mem_req          = (bus.mem_op_i != RAM_NOP);
    assign unused_addr_bits = ^{bus.if_addr_i[31:22], bus.mem_addr_i[31:22]};

    always_comb begin
        state_d      = state_q;
        ram_op_d     = ram_op_q;
        ram_addr_d   = ram_addr_q;
        store_data_d = store_data_q;
        if_data_d    = if_data_q;
        mem_rdata_d  = mem_rdata_q;
        err_mem_d    = err_mem_q;
        if_ready_d   = 1'b0;
        mem_ready_d  = 1'b0;
        addr_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_req) begin
                    if (mem_misaligned) begin
                        addr_err_d = 1'b1;
                        err_mem_d  = 1'b1;
                        state_d    = GAP;
                    end else begin
                        ram_op_d     = bus.mem_op_i;
                        ram_addr_d   = bus.mem_addr_i[21:2];
                        store_data_d = aligned_wdata;
                        state_d      = DATA;
                    end
                end else if (bus.if_req_i) begin
                    if (bus.if_addr_i[1:0] != 2'b00) begin
                        addr_err_d = 1'b1;
                        err_mem_d  = 1'b0;
                        state_d    = GAP;
                    end else begin
                        ram_op_d     = MEM_LW;
                        ram_addr_d   = bus.if_addr_i[21:2];
                        store_data_d = 32'h0;
                        state_d      = INST;
                    end
                end
            end
            DATA: begin
                if (bus.success_i) begin
                    mem_rdata_d = bus.loadData_i;
                    mem_ready_d = 1'b1;
                    ram_op_d    = RAM_NOP;
                    state_d     = GAP;
                end
            end
            INST: begin
                if (bus.success_i) begin
                    if_data_d  = bus.loadData_i;
                    if_ready_d = 1'b1;
                    ram_op_d   = RAM_NOP;
                    state_d    = GAP;
                end
            end
            // One dead cycle lets the controller settle and the requester drop its level.
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk50 or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            ram_op_q     <= RAM_NOP;
            ram_addr_q   <= 20'h0;
            store_data_q <= 32'h0;
            if_data_q    <= 32'h0;
            mem_rdata_q  <= 32'h0;
            if_ready_q   <= 1'b0;
            mem_ready_q  <= 1'b0;
            addr_err_q   <= 1'b0;
            err_mem_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ram_op_q     <= ram_op_d;
            ram_addr_q   <= ram_addr_d;
            store_data_q <= store_data_d;
            if_data_q    <= if_data_d;
            mem_rdata_q  <= mem_rdata_d;
            if_ready_q   <= if_ready_d;
            mem_ready_q  <= mem_ready_d;
            addr_err_q   <= addr_err_d;
            err_mem_q    <= err_mem_d;
        end
    end

    // A pulse only releases the port it belongs to; the other port may still be waiting.
    assign if_done  = if_ready_q | (addr_err_q & ~err_mem_q);
    assign mem_done = mem_ready_q | (addr_err_q & err_mem_q);

    assign bus.stall_o     = (bus.if_req_i & ~if_done) | (mem_req & ~mem_done);
    assign bus.ramOp_o     = ram_op_q;
    assign bus.ramAddr_o   = ram_addr_q;
    assign bus.storeData_o = store_data_q;
    assign bus.if_data_o   = if_data_q;
    assign bus.if_ready_o  = if_ready_q;
    assign bus.mem_rdata_o = mem_rdata_q;
    assign bus.mem_ready_o = mem_ready_q;
    assign bus.addr_err_o  = addr_err_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed and randomized bench for sram_arbiter against a transaction model
module tb_sram_arbiter;
    import sram_arbiter_pkg::*;

    logic clk50 = 1'b0;
    logic rst   = 1'b1;

    sram_arbiter_if bus ();

    sram_arbiter dut (
        .clk50 (clk50),
        .rst   (rst),
        .bus   (bus.slave)
    );

    always #10 clk50 = ~clk50;

    localparam int P_NONE = 0;
    localparam int P_MEM  = 1;
    localparam int P_IF   = 2;

    int          n_pass = 0;
    int          n_checks = 0;
    int          inflight = P_NONE;
    bit          prev_idle = 1'b1;
    mem_op_t     held_op = RAM_NOP;
    logic [19:0] held_addr = '0;
    logic [31:0] held_data = '0;
    logic [31:0] last_load = '0;
    int          age = 0;
    int          lat = 1;
    bit          rand_mode = 1'b0;
    bit          mem_done = 1'b0;
    bit          if_done = 1'b0;
    int          mem_ready_cnt = 0;
    int          if_ready_cnt = 0;
    int          err_cnt = 0;
    bit          got_ready;
    mem_op_t     ops [8] = '{MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_SB, MEM_SH, MEM_SW};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
    endtask

    function automatic int op_size(input mem_op_t op);
        case (op)
            MEM_LW, MEM_SW:          return 4;
            MEM_LH, MEM_LHU, MEM_SH: return 2;
            default:                 return 1;
        endcase
    endfunction

    function automatic bit is_store(input mem_op_t op);
        return (op == MEM_SW) || (op == MEM_SH) || (op == MEM_SB);
    endfunction

    function automatic bit misaligned(input mem_op_t op, input logic [31:0] addr);
        return (int'(addr[1:0]) % op_size(op)) != 0;
    endfunction

    function automatic logic [31:0] lane_data(input mem_op_t op, input logic [31:0] wdata);
        if (is_store(op)) return wdata << (8 * (4 - op_size(op)));
        return 32'h0;
    endfunction

    // One clock: check every DUT output against the transaction model, then play the controller.
    task automatic tick();
        bit          exp_err_mem, exp_err_if, exp_mem_rdy, exp_if_rdy, exp_stall;
        int          exp_issue;
        mem_op_t     e_op;
        logic [19:0] e_addr;
        logic [31:0] e_data;
        @(posedge clk50);
        #1;
        mem_done = 1'b0;
        if_done  = 1'b0;
        if (rst) begin
            inflight      = P_NONE;
            prev_idle     = 1'b1;
            age           = 0;
            bus.success_i = 1'b0;
            return;
        end
        exp_err_mem = 1'b0;
        exp_err_if  = 1'b0;
        exp_issue   = P_NONE;
        e_op        = RAM_NOP;
        e_addr      = '0;
        e_data      = '0;
        if (prev_idle) begin
            if (bus.mem_op_i != RAM_NOP) begin
                if (misaligned(bus.mem_op_i, bus.mem_addr_i)) exp_err_mem = 1'b1;
                else begin
                    exp_issue = P_MEM;
                    e_op      = bus.mem_op_i;
                    e_addr    = bus.mem_addr_i[21:2];
                    e_data    = lane_data(bus.mem_op_i, bus.mem_wdata_i);
                end
            end else if (bus.if_req_i) begin
                if (bus.if_addr_i[1:0] != 2'b00) exp_err_if = 1'b1;
                else begin
                    exp_issue = P_IF;
                    e_op      = MEM_LW;
                    e_addr    = bus.if_addr_i[21:2];
                end
            end
        end
        exp_mem_rdy = bus.success_i && (inflight == P_MEM);
        exp_if_rdy  = bus.success_i && (inflight == P_IF);
        check("addr_err", 32'(bus.addr_err_o), 32'(exp_err_mem | exp_err_if));
        check("mem_ready", 32'(bus.mem_ready_o), 32'(exp_mem_rdy));
        check("if_ready", 32'(bus.if_ready_o), 32'(exp_if_rdy));
        if (exp_mem_rdy) check("mem_rdata", bus.mem_rdata_o, last_load);
        if (exp_if_rdy) check("if_data", bus.if_data_o, last_load);
        if (exp_mem_rdy || exp_if_rdy) inflight = P_NONE;
        if (exp_issue != P_NONE) begin
            inflight  = exp_issue;
            held_op   = e_op;
            held_addr = e_addr;
            held_data = e_data;
        end
        if (inflight != P_NONE) begin
            check("ram_op", 32'(bus.ramOp_o), 32'(held_op));
            check("ram_addr", 32'(bus.ramAddr_o), 32'(held_addr));
            check("store_data", bus.storeData_o, held_data);
        end else begin
            check("ram_op_nop", 32'(bus.ramOp_o), 32'(RAM_NOP));
        end
        exp_stall = (bus.if_req_i && !(exp_if_rdy || exp_err_if)) ||
                    ((bus.mem_op_i != RAM_NOP) && !(exp_mem_rdy || exp_err_mem));
        check("stall", 32'(bus.stall_o), 32'(exp_stall));
        mem_done  = exp_mem_rdy || exp_err_mem;
        if_done   = exp_if_rdy || exp_err_if;
        prev_idle = (inflight == P_NONE) && !(mem_done || if_done);
        if (bus.mem_ready_o) mem_ready_cnt++;
        if (bus.if_ready_o) if_ready_cnt++;
        if (bus.addr_err_o) err_cnt++;

        bus.success_i = 1'b0;
        if (bus.ramOp_o == RAM_NOP) begin
            age = 0;
            if (rand_mode && $urandom_range(0, 4) == 0) begin
                bus.success_i  = 1'b1;
                bus.loadData_i = $urandom;
            end
        end else begin
            age++;
            if (age == 1) lat = rand_mode ? int'($urandom_range(1, 4)) : (is_store(bus.ramOp_o) ? 3 : 1);
            if (age == lat + 1) begin
                bus.success_i  = 1'b1;
                bus.loadData_i = $urandom;
                last_load      = bus.loadData_i;
            end
        end
    endtask

    initial begin
        bus.if_req_i    = 1'b0;
        bus.if_addr_i   = '0;
        bus.mem_op_i    = MEM_LW;
        bus.mem_addr_i  = 32'h0000_0100;
        bus.mem_wdata_i = '0;
        bus.loadData_i  = '0;
        bus.success_i   = 1'b0;

        // Reset with a load held: everything registered stays zero.
        tick();
        tick();
        check("rst_ram_op", 32'(bus.ramOp_o), 32'(RAM_NOP));
        check("rst_ram_addr", 32'(bus.ramAddr_o), 32'h0);
        check("rst_store_data", bus.storeData_o, 32'h0);
        check("rst_if_data", bus.if_data_o, 32'h0);
        check("rst_mem_rdata", bus.mem_rdata_o, 32'h0);
        check("rst_pulses", {29'h0, bus.if_ready_o, bus.mem_ready_o, bus.addr_err_o}, 32'h0);
        rst = 1'b0;
        tick();
        check("t1_op_c1", 32'(bus.ramOp_o), 32'(MEM_LW));
        check("t1_addr_c1", 32'(bus.ramAddr_o), 32'h0_0040);
        tick();
        check("t1_ready_c2", 32'(bus.mem_ready_o), 32'h0);
        tick();
        check("t1_ready_c3", 32'(bus.mem_ready_o), 32'h1);
        bus.mem_op_i = RAM_NOP;
        tick();

        // Byte store: top-lane data, ready on cycle 5.
        bus.mem_op_i    = MEM_SB;
        bus.mem_addr_i  = 32'h0000_0105;
        bus.mem_wdata_i = 32'h1234_56AB;
        tick();
        check("t2_op", 32'(bus.ramOp_o), 32'(MEM_SB));
        check("t2_addr", 32'(bus.ramAddr_o), 32'h0_0041);
        check("t2_data", bus.storeData_o, 32'hAB00_0000);
        tick();
        tick();
        tick();
        check("t2_ready_c4", 32'(bus.mem_ready_o), 32'h0);
        tick();
        check("t2_ready_c5", 32'(bus.mem_ready_o), 32'h1);
        bus.mem_op_i = RAM_NOP;
        tick();

        // Simultaneous fetch and load: data first, fetch after the gap.
        bus.if_req_i   = 1'b1;
        bus.if_addr_i  = 32'h0000_2000;
        bus.mem_op_i   = MEM_LW;
        bus.mem_addr_i = 32'h0000_3004;
        #1;
        check("t3_stall_c0", 32'(bus.stall_o), 32'h1);
        tick();
        check("t3_op_c1", 32'(bus.ramOp_o), 32'(MEM_LW));
        check("t3_addr_c1", 32'(bus.ramAddr_o), 32'h0_0C01);
        tick();
        tick();
        check("t3_mem_ready_c3", 32'(bus.mem_ready_o), 32'h1);
        check("t3_stall_c3", 32'(bus.stall_o), 32'h1);
        bus.mem_op_i = RAM_NOP;
        tick();
        check("t3_gap_op_c4", 32'(bus.ramOp_o), 32'(RAM_NOP));
        tick();
        check("t3_fetch_addr_c5", 32'(bus.ramAddr_o), 32'h0_0800);
        tick();
        tick();
        check("t3_if_ready_c7", 32'(bus.if_ready_o), 32'h1);
        check("t3_stall_c7", 32'(bus.stall_o), 32'h0);
        bus.if_req_i = 1'b0;
        tick();

        // Misaligned word load: error pulse, no access.
        bus.mem_op_i   = MEM_LW;
        bus.mem_addr_i = 32'h0000_0002;
        tick();
        check("t4_err_c1", 32'(bus.addr_err_o), 32'h1);
        check("t4_op_c1", 32'(bus.ramOp_o), 32'(RAM_NOP));
        bus.mem_op_i = RAM_NOP;
        tick();
        check("t4_err_c2", 32'(bus.addr_err_o), 32'h0);

        // Back-to-back fetches with the request level held throughout.
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h0000_0040;
        tick();
        check("t5_addr_a", 32'(bus.ramAddr_o), 32'h0_0010);
        tick();
        tick();
        check("t5_ready_a", 32'(bus.if_ready_o), 32'h1);
        bus.if_addr_i = 32'h0000_0044;
        tick();
        check("t5_gap_op", 32'(bus.ramOp_o), 32'(RAM_NOP));
        tick();
        check("t5_addr_b", 32'(bus.ramAddr_o), 32'h0_0011);
        tick();
        tick();
        check("t5_ready_b", 32'(bus.if_ready_o), 32'h1);
        bus.if_req_i = 1'b0;
        tick();

        // Reset in the middle of a store: op drops at once, retry completes afterwards.
        bus.mem_op_i    = MEM_SW;
        bus.mem_addr_i  = 32'h0000_0010;
        bus.mem_wdata_i = 32'hCAFE_F00D;
        tick();
        check("t6_op_c1", 32'(bus.ramOp_o), 32'(MEM_SW));
        tick();
        #3 rst = 1'b1;
        #1;
        check("t6_rst_op", 32'(bus.ramOp_o), 32'(RAM_NOP));
        tick();
        check("t6_rst_ready", 32'(bus.mem_ready_o), 32'h0);
        tick();
        rst = 1'b0;
        got_ready = 1'b0;
        for (int i = 0; i < 12 && !got_ready; i++) begin
            tick();
            got_ready = mem_done;
        end
        check("t6_retry_ready", 32'(got_ready), 32'h1);
        bus.mem_op_i = RAM_NOP;
        tick();

        // Randomized traffic with random controller latency and stray success pulses.
        rand_mode     = 1'b1;
        mem_ready_cnt = 0;
        if_ready_cnt  = 0;
        err_cnt       = 0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (mem_done) bus.mem_op_i = RAM_NOP;
            if (if_done) bus.if_req_i = 1'b0;
            if (bus.mem_op_i == RAM_NOP && $urandom_range(0, 3) == 0) begin
                bus.mem_op_i    = ops[$urandom_range(0, 7)];
                bus.mem_addr_i  = $urandom;
                bus.mem_wdata_i = $urandom;
                if ($urandom_range(0, 1) == 0) bus.mem_addr_i[1:0] = 2'b00;
            end
            if (!bus.if_req_i && $urandom_range(0, 2) == 0) begin
                bus.if_req_i  = 1'b1;
                bus.if_addr_i = $urandom;
                if ($urandom_range(0, 7) != 0) bus.if_addr_i[1:0] = 2'b00;
            end
        end
        bus.mem_op_i = RAM_NOP;
        bus.if_req_i = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check("rand_mem_readies", 32'(mem_ready_cnt > 0), 32'h1);
        check("rand_if_readies", 32'(if_ready_cnt > 0), 32'h1);
        check("rand_errors", 32'(err_cnt > 0), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
